// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, branch forwarding, load-use detection and a long-op
// (mul/div) scoreboard that stalls ID on RAW/WAW conflicts or a full unit.
module fwd_hazard_unit #(
  parameter int NUM_STG    = 2,
  parameter int ID_FWD_STG = 1,
  parameter int MAX_LONG   = 2,
  parameter int SEL_W      = $clog2(NUM_STG + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           rs1_address_id_i,
  input  logic [4:0]           rs2_address_id_i,
  input  logic [4:0]           rd_address_id_i,
  input  logic                 rd_we_id_i,
  input  logic                 long_id_i,
  input  logic [4:0]           rs1_address_ex_i,
  input  logic [4:0]           rs2_address_ex_i,
  input  logic [4:0]           rd_address_ex_i,
  input  logic                 mem_read_ex_i,
  input  logic                 issue_long_i,
  input  logic [NUM_STG-1:0]   rd_we_stg_i,
  input  logic [5*NUM_STG-1:0] rd_address_stg_i,
  input  logic                 long_done_i,
  input  logic [4:0]           long_rd_i,
  output logic [SEL_W-1:0]     alu_forward_a_o,
  output logic [SEL_W-1:0]     alu_forward_b_o,
  output logic [SEL_W-1:0]     branch_forward_a_o,
  output logic [SEL_W-1:0]     branch_forward_b_o,
  output logic                 stall_id_o,
  output logic                 long_full_o,
  output logic [31:0]          busy_o,
  output logic                 sb_err_o
);

  localparam int CNT_W = $clog2(MAX_LONG + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LONG);

  logic [4:0] stg_rd [NUM_STG];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STG; gi++) begin : g_stg_rd
      assign stg_rd[gi] = rd_address_stg_i[5*gi +: 5];
    end
  endgenerate

  // Walk from oldest to youngest so the youngest matching stage overrides.
  always_comb begin
    alu_forward_a_o    = '0;
    alu_forward_b_o    = '0;
    branch_forward_a_o = '0;
    branch_forward_b_o = '0;
    for (int k = NUM_STG - 1; k >= 0; k--) begin
      if (rd_we_stg_i[k]) begin
        if (rs1_address_ex_i != 5'd0 && stg_rd[k] == rs1_address_ex_i)
          alu_forward_a_o = SEL_W'(k + 1);
        if (rs2_address_ex_i != 5'd0 && stg_rd[k] == rs2_address_ex_i)
          alu_forward_b_o = SEL_W'(k + 1);
        if (k < ID_FWD_STG) begin
          if (rs1_address_id_i != 5'd0 && stg_rd[k] == rs1_address_id_i)
            branch_forward_a_o = SEL_W'(k + 1);
          if (rs2_address_id_i != 5'd0 && stg_rd[k] == rs2_address_id_i)
            branch_forward_b_o = SEL_W'(k + 1);
        end
      end
    end
  end

  logic [31:0]      busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (long_done_i) begin
      if (busy_q[long_rd_i]) busy_d[long_rd_i] = 1'b0;
      else                   err_d = 1'b1;
    end
    // Applied after the clear so a same-cycle set wins.
    if (issue_long_i && rd_address_ex_i != 5'd0) busy_d[rd_address_ex_i] = 1'b1;
    if (issue_long_i && !long_done_i) begin
      if (cnt_q == CNT_MAX) err_d = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end else if (long_done_i && !issue_long_i) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  logic load_use, raw_waw, issue_hit, structural;

  always_comb begin
    load_use = mem_read_ex_i && rd_address_ex_i != 5'd0 &&
               (rd_address_ex_i == rs1_address_id_i || rd_address_ex_i == rs2_address_id_i);
    issue_hit = issue_long_i && rd_address_ex_i != 5'd0 &&
                (rd_address_ex_i == rs1_address_id_i || rd_address_ex_i == rs2_address_id_i ||
                 (rd_we_id_i && rd_address_ex_i == rd_address_id_i));
    raw_waw = busy_q[rs1_address_id_i] || busy_q[rs2_address_id_i] ||
              (rd_we_id_i && busy_q[rd_address_id_i]) || issue_hit;
    structural = long_id_i && long_full_o;
  end

  assign long_full_o = (cnt_q == CNT_MAX);
  assign stall_id_o  = load_use || raw_waw || structural;
  assign busy_o      = busy_q;
  assign sb_err_o    = err_q;

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard-detection unit for the rv32im_zbb pipeline, the successor to the fixed MEM/WB forwarding logic. It generates ALU operand forward selects over a configurable number of post-EX stages and branch-operand forward selects in ID. It also detects load-use hazards and keeps a registered scoreboard of in-flight long-latency (mul/div) writebacks, stalling ID on RAW/WAW conflicts or when the long-op unit is full. It sits beside the ID/EX pipeline registers and drives the operand muxes and the IF/ID stall/EX-bubble controls.

## Interface
- NUM_STG, 2: post-EX stages with forward paths; stage 0 is youngest (MEM), stage NUM_STG-1 oldest (WB); 1..6
- ID_FWD_STG, 1: stages 0..ID_FWD_STG-1 may forward to ID branch operands; 0..NUM_STG
- MAX_LONG, 2: max outstanding long ops; 1..15
- SEL_W, $clog2(NUM_STG+1): derived, do not override

- clk  in  1  clock; all state rises on posedge
- reset  in  1  synchronous, active-high
- rs1_address_id_i / rs2_address_id_i  in  5  ID source registers
- rd_address_id_i  in  5  ID destination
- rd_we_id_i  in  1  ID instruction writes rd
- long_id_i  in  1  ID instruction is mul/div
- rs1_address_ex_i / rs2_address_ex_i  in  5  EX source registers
- rd_address_ex_i  in  5  EX destination
- mem_read_ex_i  in  1  EX instruction is a load
- issue_long_i  in  1  long op leaves EX into mul/div unit this cycle
- rd_we_stg_i  in  NUM_STG  per-stage write enable
- rd_address_stg_i  in  5*NUM_STG  per-stage rd, stage k at bits [5k+4:5k]
- long_done_i  in  1  long op writes back this cycle
- long_rd_i  in  5  destination of completing long op
- alu_forward_a_o / alu_forward_b_o  out  SEL_W  0 = regfile/ID/EX value, k = stage k-1
- branch_forward_a_o / branch_forward_b_o  out  SEL_W  same encoding, limited to ID_FWD_STG
- stall_id_o  out  1  hold PC and IF/ID, insert bubble into EX
- long_full_o  out  1  outstanding count == MAX_LONG
- busy_o  out  32  scoreboard vector (bit 0 always 0)
- sb_err_o  out  1  sticky: completion for non-busy register

## Operation
- ALU forward: for each EX source, select the lowest k with rd_we_stg_i[k] and address match; youngest wins. Source x0 never forwards (select 0).
- Branch forward: same rule restricted to k < ID_FWD_STG; ID_FWD_STG=0 forces 0.
- Load-use: stall when mem_read_ex_i, rd_address_ex_i != 0, and it matches either ID source.
- Scoreboard busy[31:0], registered:
  - issue_long_i with issue rd != 0 sets busy[rd]; long_done_i clears busy[long_rd_i].
  - Same register set and cleared in one cycle: set wins.
  - long_done_i for a register with busy == 0: no change, sb_err_o set until reset.
- RAW/WAW stall: stall when an ID source or (rd_we_id_i and rd_address_id_i) matches a busy bit. Also stall combinationally when issue_long_i is high with the same rd this cycle, which closes the one-cycle scoreboard gap.
- Counter long_cnt, 0..MAX_LONG:
  - Increment on issue, decrement on done; both in one cycle leaves it unchanged.
  - No increment past MAX_LONG, no decrement below 0; either attempt sets sb_err_o.
- Structural stall: long_id_i while long_full_o is high.
- stall_id_o is the OR of the load-use, RAW/WAW and structural terms. This unit does not gate or modify its own inputs.

## Timing
- Forward selects and stall_id_o are combinational from inputs plus registered state; no added latency.
- busy, long_cnt and sb_err_o update on posedge; a new busy bit is visible to the RAW/WAW logic one cycle after issue.
- Reset (including mid-operation): busy=0, long_cnt=0, sb_err_o=0, long_full_o=0. Forward selects and stall follow the combinational inputs from the first cycle after reset.
- A long op that completes while stall_id_o is high releases the stall in the following cycle.

## Test plan
- NUM_STG=3, stage0 and stage2 both write x5, EX rs1=x5 -> alu_forward_a_o=1; clear stage0 write -> 3; rs1=x0 with all stages writing x0 -> 0.
- Load x7 in EX, ID rs2=x7 -> stall_id_o=1 for exactly that cycle; rd_address_ex_i=x0 -> stall_id_o=0.
- issue_long_i rd=x9, ID rs1=x9 -> stall same cycle and every following cycle; long_done_i rd=x9 -> busy_o[9]=0 next cycle, stall drops.
- MAX_LONG=2, two issues -> long_full_o=1, ID long op stalls; issue and done in one cycle -> count stays 2.
- long_done_i rd=x3 with x3 not busy -> sb_err_o=1 held; reset -> all outputs cleared.
- Set and clear x4 in the same cycle -> busy_o[4]=1.
